// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU command interface.
//   - 4-bit FPU command codes (single and double precision add/mul/div)
//   - response status encoding returned to the host
//   - issuer FSM state encoding
//   - is_dp_cmd(): true for the double-precision opcodes the issuer forwards
package fpu_pkg;

   localparam logic [3:0] CMD_NONE   = 4'b0000;
   localparam logic [3:0] CMD_SP_ADD = 4'b0001;
   localparam logic [3:0] CMD_SP_MUL = 4'b0010;
   localparam logic [3:0] CMD_SP_DIV = 4'b0011;
   localparam logic [3:0] CMD_DP_ADD = 4'b0101;
   localparam logic [3:0] CMD_DP_MUL = 4'b0110;
   localparam logic [3:0] CMD_DP_DIV = 4'b0111;

   typedef enum logic [1:0] {
      RSP_OK      = 2'b00,
      RSP_BADCMD  = 2'b01,
      RSP_TIMEOUT = 2'b10
   } rsp_status_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10,
      ST_RESP  = 2'b11
   } issuer_state_e;

   function automatic logic is_dp_cmd(input logic [3:0] cmd);
      return (cmd == CMD_DP_ADD) || (cmd == CMD_DP_MUL) || (cmd == CMD_DP_DIV);
   endfunction

endpackage

// File: rtl/fpu_dp_issuer.sv
// Initiator-side sequencer for the double-precision FPU command interface.
// Accepts one host request at a time, rejects non-DP opcodes, issues the
// operation to the FPU with a single-cycle dval pulse, waits for rdy with a
// timeout and returns result/tag/status on a valid/ready response channel.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            host request handshake
//   req_cmd/req_din1/req_din2/tag  request opcode, operands, host tag
//   rsp_valid/rsp_ready            host response handshake
//   rsp_result/rsp_tag/rsp_status  response payload (result is 0 on error)
//   fpu_cmd/fpu_din1/fpu_din2      command and operands to the FPU, held stable
//   fpu_dval                       single-cycle start pulse
//   fpu_result/fpu_rdy             FPU completion
//   busy                           any state other than IDLE
//   err_cnt                        saturating count of BADCMD + TIMEOUT responses
//
// state | meaning
// IDLE  | ready for a request, fpu_cmd parked at 0000
// ISSUE | dval pulse cycle, timeout counter loaded
// WAIT  | operands held, waiting for fpu_rdy or timeout
// RESP  | response presented until rsp_ready
module fpu_dp_issuer
   import fpu_pkg::*;
#(
   parameter int TIMEOUT = 1023,
   parameter int TMO_W   = 10,
   parameter int ERR_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_cmd,
   input  logic [63:0]      req_din1,
   input  logic [63:0]      req_din2,
   input  logic [3:0]       req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [63:0]      rsp_result,
   output logic [3:0]       rsp_tag,
   output logic [1:0]       rsp_status,
   output logic [3:0]       fpu_cmd,
   output logic [63:0]      fpu_din1,
   output logic [63:0]      fpu_din2,
   output logic             fpu_dval,
   input  logic [63:0]      fpu_result,
   input  logic             fpu_rdy,
   output logic             busy,
   output logic [ERR_W-1:0] err_cnt
);

   // Down-counter terminal value reached in the (TIMEOUT-1)th WAIT cycle, so
   // a timeout response appears TIMEOUT cycles after the dval pulse.
   localparam logic [TMO_W-1:0] TMO_LOAD = (TIMEOUT > 1) ? TMO_W'(TIMEOUT - 2) : '0;

   issuer_state_e    state_q, state_d;
   logic [3:0]       fpu_cmd_q, fpu_cmd_d;
   logic [63:0]      fpu_din1_q, fpu_din1_d;
   logic [63:0]      fpu_din2_q, fpu_din2_d;
   logic             fpu_dval_q, fpu_dval_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [63:0]      rsp_result_q, rsp_result_d;
   logic [3:0]       rsp_tag_q, rsp_tag_d;
   rsp_status_e      rsp_status_q, rsp_status_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic             err_inc;

   always_comb begin
      state_d      = state_q;
      fpu_cmd_d    = fpu_cmd_q;
      fpu_din1_d   = fpu_din1_q;
      fpu_din2_d   = fpu_din2_q;
      fpu_dval_d   = 1'b0;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_tag_d    = rsp_tag_q;
      rsp_status_d = rsp_status_q;
      tmo_d        = tmo_q;
      err_inc      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               rsp_tag_d = req_tag;
               if (is_dp_cmd(req_cmd)) begin
                  fpu_cmd_d  = req_cmd;
                  fpu_din1_d = req_din1;
                  fpu_din2_d = req_din2;
                  fpu_dval_d = 1'b1;
                  state_d    = ST_ISSUE;
               end else begin
                  rsp_result_d = '0;
                  rsp_status_d = RSP_BADCMD;
                  rsp_valid_d  = 1'b1;
                  err_inc      = 1'b1;
                  state_d      = ST_RESP;
               end
            end
         end
         ST_ISSUE: begin
            tmo_d   = TMO_LOAD;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // rdy is checked first so it wins over a coincident timeout
            if (fpu_rdy) begin
               rsp_result_d = fpu_result;
               rsp_status_d = RSP_OK;
               rsp_valid_d  = 1'b1;
               state_d      = ST_RESP;
            end else if ((TIMEOUT != 0) && (tmo_q == '0)) begin
               rsp_result_d = '0;
               rsp_status_d = RSP_TIMEOUT;
               rsp_valid_d  = 1'b1;
               err_inc      = 1'b1;
               state_d      = ST_RESP;
            end else begin
               tmo_d = tmo_q - 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               fpu_cmd_d   = CMD_NONE;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      err_cnt_d = (err_inc && (err_cnt_q != '1)) ? err_cnt_q + 1'b1 : err_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         fpu_cmd_q    <= CMD_NONE;
         fpu_din1_q   <= '0;
         fpu_din2_q   <= '0;
         fpu_dval_q   <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_tag_q    <= '0;
         rsp_status_q <= RSP_OK;
         tmo_q        <= '0;
         err_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         fpu_cmd_q    <= fpu_cmd_d;
         fpu_din1_q   <= fpu_din1_d;
         fpu_din2_q   <= fpu_din2_d;
         fpu_dval_q   <= fpu_dval_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_tag_q    <= rsp_tag_d;
         rsp_status_q <= rsp_status_d;
         tmo_q        <= tmo_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign fpu_cmd    = fpu_cmd_q;
   assign fpu_din1   = fpu_din1_q;
   assign fpu_din2   = fpu_din2_q;
   assign fpu_dval   = fpu_dval_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_tag    = rsp_tag_q;
   assign rsp_status = rsp_status_q;
   assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_fpu_dp_issuer.sv
// Self-checking bench for fpu_dp_issuer with a behavioural FPU model whose
// completion latency is chosen per request; the expected response is derived
// from the request and latency using real arithmetic and the timing rules.
module tb_fpu_dp_issuer;

   localparam int TMO = 8;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_cmd;
   logic [63:0] req_din1;
   logic [63:0] req_din2;
   logic [3:0]  req_tag;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_result;
   logic [3:0]  rsp_tag;
   logic [1:0]  rsp_status;
   logic [3:0]  fpu_cmd;
   logic [63:0] fpu_din1;
   logic [63:0] fpu_din2;
   logic        fpu_dval;
   logic [63:0] fpu_result;
   logic        fpu_rdy;
   logic        busy;
   logic [7:0]  err_cnt;

   int n_checks = 0;
   int n_pass   = 0;
   int err_exp  = 0;

   // FPU model controls / state
   int          fpu_lat       = 0;   // 0 = never completes
   bit          stray_at_dval = 0;   // raise rdy during the dval cycle
   int          pend          = 0;
   int          dval_cnt      = 0;
   logic [63:0] m_res         = '0;

   fpu_dp_issuer #(.TIMEOUT(TMO), .TMO_W(10), .ERR_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
      .req_din1(req_din1), .req_din2(req_din2), .req_tag(req_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_tag(rsp_tag), .rsp_status(rsp_status),
      .fpu_cmd(fpu_cmd), .fpu_din1(fpu_din1), .fpu_din2(fpu_din2), .fpu_dval(fpu_dval),
      .fpu_result(fpu_result), .fpu_rdy(fpu_rdy),
      .busy(busy), .err_cnt(err_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [63:0] fp_ref(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
      real x, y, r;
      x = $bitstoreal(a);
      y = $bitstoreal(b);
      case (c)
         4'b0101: r = x + y;
         4'b0110: r = x * y;
         default: r = x / y;
      endcase
      return $realtobits(r);
   endfunction

   function automatic logic [63:0] rand_op();
      real v;
      v = real'($urandom_range(1, 4000)) / 16.0;
      return $realtobits(v);
   endfunction

   // FPU: completes fpu_lat cycles after the dval cycle; deselection
   // (fpu_cmd == 0000) cancels a pending completion. Outside rdy the result
   // bus carries garbage so a mistimed capture is visible.
   initial begin
      fpu_rdy    = 1'b0;
      fpu_result = '0;
      forever begin
         @(negedge clk);
         fpu_rdy    = 1'b0;
         fpu_result = {$urandom, $urandom};
         if (fpu_cmd === 4'b0000) pend = 0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               fpu_rdy    = 1'b1;
               fpu_result = m_res;
            end
         end
         if (fpu_dval === 1'b1) begin
            dval_cnt++;
            m_res = fp_ref(fpu_cmd, fpu_din1, fpu_din2);
            pend  = fpu_lat;
            if (stray_at_dval) fpu_rdy = 1'b1;
         end
      end
   end

   // One complete request/response transaction, called at a negedge in IDLE.
   task automatic do_op(input logic [3:0] cmd, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] tag, input int lat, input int hold,
                        input bit stray, input string nm);
      bit          dp;
      int          exp_k;
      int          k;
      int          d0;
      logic [63:0] exp_res;
      logic [1:0]  exp_st;
      dp = (cmd == 4'b0101) || (cmd == 4'b0110) || (cmd == 4'b0111);
      if (!dp) begin
         exp_k = 1; exp_res = '0; exp_st = 2'b01;
      end else if (lat >= 1 && lat <= TMO - 1) begin
         exp_k = lat + 2; exp_res = fp_ref(cmd, a, b); exp_st = 2'b00;
      end else begin
         exp_k = TMO + 1; exp_res = '0; exp_st = 2'b10;
      end
      if (exp_st != 2'b00 && err_exp < 255) err_exp++;
      fpu_lat       = lat;
      stray_at_dval = stray;
      d0            = dval_cnt;

      req_valid = 1'b1; req_cmd = cmd; req_din1 = a; req_din2 = b; req_tag = tag;
      @(negedge clk);
      req_valid = 1'b0; req_cmd = 4'($urandom); req_din1 = {$urandom, $urandom}; req_tag = 4'($urandom);
      k = 1;
      n_checks++;
      if (fpu_dval !== dp) $display("FAIL %s dval: got %b want %b", nm, fpu_dval, dp);
      else n_pass++;
      if (dp) begin
         n_checks++;
         if (fpu_cmd !== cmd || fpu_din1 !== a || fpu_din2 !== b)
            $display("FAIL %s issue: got cmd %h d1 %h d2 %h want %h %h %h", nm, fpu_cmd, fpu_din1, fpu_din2, cmd, a, b);
         else n_pass++;
      end
      while (rsp_valid !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (k !== exp_k) $display("FAIL %s latency: got %0d want %0d", nm, k, exp_k);
      else n_pass++;
      n_checks++;
      if (rsp_result !== exp_res || rsp_tag !== tag || rsp_status !== exp_st)
         $display("FAIL %s rsp: got %h/%h/%b want %h/%h/%b", nm, rsp_result, rsp_tag, rsp_status, exp_res, tag, exp_st);
      else n_pass++;
      n_checks++;
      if (err_cnt !== 8'(err_exp)) $display("FAIL %s err_cnt: got %0d want %0d", nm, err_cnt, err_exp);
      else n_pass++;
      n_checks++;
      if (fpu_cmd !== (dp ? cmd : 4'b0000) || req_ready !== 1'b0 || busy !== 1'b1)
         $display("FAIL %s resp_state: got cmd %h rr %b busy %b want %h 0 1", nm, fpu_cmd, req_ready, busy, dp ? cmd : 4'b0000);
      else n_pass++;

      for (int i = 0; i < hold; i++) begin
         req_valid = ~req_valid;
         req_cmd   = 4'b0101;
         req_din1  = rand_op();
         req_din2  = rand_op();
         @(negedge clk);
         n_checks++;
         if ({rsp_valid, rsp_result, rsp_tag, rsp_status, req_ready} !== {1'b1, exp_res, tag, exp_st, 1'b0})
            $display("FAIL %s hold%0d: got v%b %h/%h/%b rr %b want v1 %h/%h/%b rr 0",
                     nm, i, rsp_valid, rsp_result, rsp_tag, rsp_status, req_ready, exp_res, tag, exp_st);
         else n_pass++;
      end

      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b0 || fpu_cmd !== 4'b0000 || req_ready !== 1'b1 || busy !== 1'b0)
         $display("FAIL %s handshake: got v%b cmd %h rr %b busy %b want v0 0000 1 0", nm, rsp_valid, fpu_cmd, req_ready, busy);
      else n_pass++;
      n_checks++;
      if (dval_cnt !== d0 + (dp ? 1 : 0)) $display("FAIL %s dval_count: got %0d want %0d", nm, dval_cnt - d0, dp ? 1 : 0);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_cmd = '0; req_din1 = '0; req_din2 = '0; req_tag = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({fpu_cmd, fpu_din1, fpu_din2, fpu_dval, rsp_valid, rsp_result, rsp_tag, rsp_status, err_cnt, busy} !== '0)
         $display("FAIL reset_vals: got cmd %h dval %b v %b res %h tag %h st %b err %0d busy %b want all 0",
                  fpu_cmd, fpu_dval, rsp_valid, rsp_result, rsp_tag, rsp_status, err_cnt, busy);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_idle: got rr %b busy %b want 1 0", req_ready, busy);
      else n_pass++;
   endtask

   task automatic test_dp_add();
      do_op(4'b0101, 64'h3FF0000000000000, 64'h4000000000000000, 4'd3, 2, 0, 0, "dp_add");
      do_op(4'b0110, rand_op(), rand_op(), 4'd4, 1, 0, 0, "dp_mul_l1");
      do_op(4'b0111, rand_op(), rand_op(), 4'd6, 4, 1, 1, "dp_div_stray");
   endtask

   task automatic test_badcmd();
      do_op(4'b0001, rand_op(), rand_op(), 4'd5, 3, 0, 0, "badcmd");
   endtask

   task automatic test_timeout();
      do_op(4'b0110, rand_op(), rand_op(), 4'd7, 0, 0, 0, "timeout");
      do_op(4'b0101, rand_op(), rand_op(), 4'd8, TMO, 2, 0, "late_rdy");
      do_op(4'b0111, rand_op(), rand_op(), 4'd2, TMO + 2, 0, 0, "late_rdy_masked");
   endtask

   task automatic test_tie();
      do_op(4'b0111, rand_op(), rand_op(), 4'd9, TMO - 1, 0, 0, "tie");
   endtask

   task automatic test_back_to_back();
      do_op(4'b0110, rand_op(), rand_op(), 4'd11, 3, 5, 0, "rsp_hold");
      do_op(4'b0101, rand_op(), rand_op(), 4'd12, 2, 0, 0, "after_hold");
   endtask

   task automatic test_random();
      logic [3:0] c;
      for (int n = 0; n < 40; n++) begin
         c = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(5, 7)) : 4'($urandom);
         do_op(c, rand_op(), rand_op(), 4'($urandom), $urandom_range(0, TMO + 3),
               $urandom_range(0, 3), 1'($urandom), "random");
      end
   endtask

   task automatic test_err_saturate();
      logic [3:0] c;
      for (int n = 0; n < 260; n++) begin
         c = 4'($urandom);
         if (c == 4'b0101 || c == 4'b0110 || c == 4'b0111) c = 4'b1111;
         do_op(c, rand_op(), rand_op(), 4'($urandom), 1, 0, 0, "err_sat");
      end
      n_checks++;
      if (err_cnt !== 8'd255) $display("FAIL err_saturate: got %0d want 255", err_cnt);
      else n_pass++;
   endtask

   task automatic test_reset_in_wait();
      fpu_lat = 0; stray_at_dval = 0;
      req_valid = 1'b1; req_cmd = 4'b0101; req_din1 = rand_op(); req_din2 = rand_op(); req_tag = 4'hA;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || fpu_cmd !== 4'b0101) $display("FAIL rst_wait_pre: got busy %b cmd %h want 1 0101", busy, fpu_cmd);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({fpu_cmd, fpu_din1, fpu_din2, fpu_dval, rsp_valid, rsp_result, rsp_tag, rsp_status, err_cnt, busy} !== '0)
         $display("FAIL rst_wait_vals: got cmd %h v %b st %b err %0d busy %b want all 0", fpu_cmd, rsp_valid, rsp_status, err_cnt, busy);
      else n_pass++;
      err_exp = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0)
         $display("FAIL rst_wait_idle: got rr %b busy %b v %b want 1 0 0", req_ready, busy, rsp_valid);
      else n_pass++;
      do_op(4'b0110, rand_op(), rand_op(), 4'd13, 2, 0, 0, "post_reset");
   endtask

   initial begin
      test_reset();
      test_dp_add();
      test_badcmd();
      test_timeout();
      test_tie();
      test_back_to_back();
      test_random();
      test_err_saturate();
      test_reset_in_wait();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fpu_dp_issuer.md
Name: fpu_dp_issuer

Overview:
Initiator-side sequencer for the double-precision FPU command interface (cmd/din1/din2/dval in, result/rdy out). It accepts one request at a time from a host via a valid/ready handshake and validates the opcode. It drives the FPU with stable cmd/operands and a single-cycle dval pulse, waits for rdy with a timeout, then returns result, tag and status via a valid/ready response channel. It sits between a host bus/register bridge and the FPU top.

Parameters:
TIMEOUT, 1023, cycles to wait for fpu_rdy before aborting; 0 disables the timeout.
TMO_W, 10, width of the timeout counter; must satisfy TIMEOUT <= 2**TMO_W-1.
ERR_W, 8, width of the saturating error counter.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  host request valid
req_ready  out  1  issuer can accept a request
req_cmd  in  4  opcode (0101 add, 0110 mul, 0111 div)
req_din1  in  64  operand 1
req_din2  in  64  operand 2
req_tag  in  4  host tag, returned with the response
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_result  out  64  FPU result (0 on error)
rsp_tag  out  4  echoed tag
rsp_status  out  2  00 OK, 01 BADCMD, 10 TIMEOUT
fpu_cmd  out  4  command to FPU
fpu_din1  out  64  operand 1 to FPU
fpu_din2  out  64  operand 2 to FPU
fpu_dval  out  1  single-cycle start pulse
fpu_result  in  64  FPU result
fpu_rdy  in  1  FPU completion
busy  out  1  state != IDLE
err_cnt  out  ERR_W  count of BADCMD plus TIMEOUT responses, saturating

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). All flops clear on rst_n low.
- Reset values: state=IDLE, fpu_cmd=0000, fpu_din1/2=0, fpu_dval=0, rsp_valid=0, rsp_result=0, rsp_tag=0, rsp_status=00, err_cnt=0, busy=0. req_ready=1 once in IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP. Every FPU-side and response-side output is registered.
- IDLE: req_ready=1. On req_valid&&req_ready:
  - Capture cmd, operands and tag.
  - If cmd is in {0101, 0110, 0111}: load fpu_cmd/fpu_din1/fpu_din2, set fpu_dval=1, go to ISSUE.
  - Otherwise: go directly to RESP with status=BADCMD, result=0. The FPU is never touched; fpu_cmd stays 0000.
- ISSUE (one cycle): fpu_dval=1 in this cycle only, then cleared. Clear the timeout counter and go to WAIT. fpu_rdy is ignored in ISSUE.
- WAIT: fpu_cmd and operands are held stable.
  - On fpu_rdy=1: capture fpu_result, status=OK, go to RESP.
  - Otherwise increment the timer. If TIMEOUT!=0 and timer==TIMEOUT-1: status=TIMEOUT, result=0, go to RESP.
  - If rdy and the timeout occur in the same cycle, rdy wins (status OK).
- RESP: rsp_valid=1. result, tag and status stay stable until rsp_ready. On handshake: rsp_valid=0, fpu_cmd=0000, go to IDLE.
- fpu_cmd is 0000 in IDLE, so a stray rdy from any unit is deselected. fpu_rdy is ignored outside WAIT.
- Latency: request accepted at edge T gives dval high in cycle T+1. With FPU rdy in cycle T+1+L (L>=1), rsp_valid rises at T+2+L. BADCMD gives rsp_valid at T+1.
- Throughput: one outstanding operation. req_ready=0 from the accept edge until the response handshake. There is no back-to-back overlap.
- err_cnt increments on entry to RESP with status != OK and saturates at 2**ERR_W-1. It is cleared only by reset.
- Reset mid-operation: return immediately to IDLE with the reset values above. Any in-flight FPU result is dropped.
- Known limitation: after a TIMEOUT the FPU unit may still complete later. That late rdy is masked because fpu_cmd=0000.

Decomposition:
- Shared package fpu_pkg holds:
  - the FPU command codes (SP/DP add/mul/div, 4-bit);
  - a typedef enum for rsp_status {OK, BADCMD, TIMEOUT};
  - a typedef enum for the issuer FSM state;
  - a function is_dp_cmd().
- No sub-module: the FSM, timer and counter are small and live in one module.

Test Plan:
- DP add 1.0+2.0 (0x3FF0000000000000, 0x4000000000000000), tag 3 -> fpu_dval one cycle with fpu_cmd=0101; rsp_result=0x4008000000000000, tag 3, status 00.
- req_cmd=0001 (SP add, unsupported), tag 5 -> no fpu_dval; rsp_valid next cycle with result 0, status 01, err_cnt=1.
- FPU model never asserts rdy, TIMEOUT=8 -> rsp status 10 exactly 8 cycles after dval; fpu_cmd returns to 0000 after the response handshake.
- rdy and the timeout in the same cycle -> status 00, result captured, err_cnt unchanged.
- Hold rsp_ready=0 for 5 cycles, toggle req_valid -> response stable, req_ready=0, no second dval; accepted after handshake.
- 260 BADCMD requests -> err_cnt saturates at 255. Assert rst_n in WAIT -> all outputs at reset values, busy=0.
